// File: rtl/adder_axis_multi.sv
// adder_axis_multi: N-channel AXI-Stream joining adder.
// Each input channel has its own FIFO, so channels stall independently. One registered sum
// is emitted per complete operand set (one beat from every channel), at up to one per clock.
// Optional feature: define ADDER_AXIS_CNT_EN to add the 32-bit output transfer counter
// trans_cnt_o. When it is undefined, the port and the counter are absent.
module adder_axis_multi #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned OUT_WIDTH = WIDTH + $clog2(N_CH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N_CH*WIDTH-1:0] data_i_tdata,
  input  logic [N_CH-1:0]       data_i_tvalid,
  output logic [N_CH-1:0]       data_i_tready,
  output logic [OUT_WIDTH-1:0]  data_o_tdata,
  output logic                  data_o_tvalid,
  input  logic                  data_o_tready
`ifdef ADDER_AXIS_CNT_EN
  ,
  output logic [31:0]           trans_cnt_o
`endif
);

  // One extra pointer bit tells a full FIFO apart from an empty one.
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  logic [N_CH-1:0]       push;
  logic [N_CH-1:0]       empty;
  logic [N_CH-1:0]       full;
  logic [N_CH*WIDTH-1:0] head;
  logic                  all_avail;
  logic                  fire;
  logic [OUT_WIDTH-1:0]  head_sum;

  logic                  tvalid_q, tvalid_d;
  logic [OUT_WIDTH-1:0]  tdata_q, tdata_d;

  // Per-channel operand FIFO; all FIFOs pop together on fire.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;

    // Pointer advance on push / pop; both may happen in the same cycle.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push[k]) begin
        wptr_d = wptr_q + PtrW'(1);
      end
      if (fire) begin
        rptr_d = rptr_q + PtrW'(1);
      end
    end

    // Pointer registers; reset empties the FIFO and discards buffered operands.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge aclk) begin
      if (push[k]) begin
        mem_q[wptr_q[AddrW-1:0]] <= data_i_tdata[k*WIDTH +: WIDTH];
      end
    end

    assign empty[k] = (wptr_q == rptr_q);
    assign full[k]  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                      (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    // Ready comes from registered pointers only; a same-cycle pop does not free the slot.
    assign push[k]  = data_i_tvalid[k] && !full[k];
    assign head[k*WIDTH +: WIDTH] = mem_q[rptr_q[AddrW-1:0]];
  end

  assign data_i_tready = ~full;

  // A set is complete when every FIFO holds a head; the output slot must be free or draining.
  assign all_avail = &(~empty);
  assign fire      = all_avail && (!tvalid_q || data_o_tready);

  // Zero-extended sum of all heads; OUT_WIDTH is wide enough that it cannot overflow.
  always_comb begin
    head_sum = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      head_sum = head_sum + OUT_WIDTH'(head[k*WIDTH +: WIDTH]);
    end
  end

  // Output slot next state: load on fire, clear valid once consumed, otherwise hold.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (fire) begin
      tvalid_d = 1'b1;
      tdata_d  = head_sum;
    end else if (data_o_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Output register; reset drops any pending beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign data_o_tvalid = tvalid_q;
  assign data_o_tdata  = tdata_q;

`ifdef ADDER_AXIS_CNT_EN
  logic [31:0] cnt_q;

  // Count completed output transfers; wraps naturally at 2^32.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else if (tvalid_q && data_o_tready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign trans_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_adder_axis_multi.sv
// Bench for adder_axis_multi (default parameters: WIDTH=8, N_CH=4, FIFO_DEPTH=4).
// Expected sums come from the source beat tables: the i-th output must equal the plain
// integer sum of the i-th beat sent on each channel.
module tb_adder_axis_multi;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] in_tdata = '0;
  logic [3:0]  in_tvalid = '0;
  logic [3:0]  data_i_tready;
  logic [9:0]  data_o_tdata;
  logic        data_o_tvalid;
  logic        out_tready = 1'b0;
`ifdef ADDER_AXIS_CNT_EN
  logic [31:0] trans_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // Source tables and per-channel progress for the stimulus driver.
  logic [7:0] src [4][256];
  int         nbeats [4];
  int         idx [4];

  // Output log filled by the monitor.
  logic [9:0] out_log [256];
  int         out_cyc [256];
  int         out_cnt = 0;
  int         cyc = 0;

  adder_axis_multi dut (
    .aclk          (aclk),
    .areset        (areset),
    .data_i_tdata  (in_tdata),
    .data_i_tvalid (in_tvalid),
    .data_i_tready (data_i_tready),
    .data_o_tdata  (data_o_tdata),
    .data_o_tvalid (data_o_tvalid),
    .data_o_tready (out_tready)
`ifdef ADDER_AXIS_CNT_EN
    ,
    .trans_cnt_o   (trans_cnt_o)
`endif
  );

  always #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: record every output handshake, sampled mid-cycle.
  initial forever begin
    @(negedge aclk);
    if (!areset && data_o_tvalid && out_tready) begin
      if (out_cnt < 256) begin
        out_log[out_cnt] = data_o_tdata;
        out_cyc[out_cnt] = cyc;
      end
      out_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic clear_log();
    out_cnt = 0;
  endtask

  task automatic setup(input int n);
    for (int k = 0; k < 4; k++) begin
      nbeats[k] = n;
      idx[k]    = 0;
    end
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < n; i++) begin
        src[k][i] = 8'($urandom_range(255));
      end
    end
  endtask

  // Per-channel AXI masters plus random sink ready, for a fixed number of cycles.
  task automatic drive(input int cycles, input int vprob, input int rprob);
    logic [3:0] hs;
    for (int c = 0; c < cycles; c++) begin
      @(negedge aclk);
      hs = in_tvalid & data_i_tready;
      @(posedge aclk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) begin
          in_tvalid[k] = 1'b0;
          idx[k]++;
        end
        if (!in_tvalid[k] && idx[k] < nbeats[k] && int'($urandom_range(99)) < vprob) begin
          in_tvalid[k]       = 1'b1;
          in_tdata[k*8 +: 8] = src[k][idx[k]];
        end
      end
      out_tready = (int'($urandom_range(99)) < rprob);
    end
  endtask

  task automatic test_reset();
    areset     = 1'b1;
    in_tvalid  = '0;
    out_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (data_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_tvalid: got %0b expected 0", data_o_tvalid);
    end
    checks++;
    if (data_o_tdata !== 10'd0) begin
      errors++;
      $display("FAIL reset_tdata: got %0d expected 0", data_o_tdata);
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (data_i_tready !== 4'hF) begin
      errors++;
      $display("FAIL reset_tready: got %b expected 1111", data_i_tready);
    end
  endtask

  task automatic test_defaults();
    clear_log();
    out_tready = 1'b1;
    @(posedge aclk);
    #1;
    in_tdata  = {8'd4, 8'd3, 8'd2, 8'd1};
    in_tvalid = 4'hF;
    @(negedge aclk);
    checks++;
    if (data_o_tvalid !== 1'b0 || data_o_tdata !== 10'd0) begin
      errors++;
      $display("FAIL defaults_before: got valid=%0b data=%0d expected valid=0 data=0",
               data_o_tvalid, data_o_tdata);
    end
    @(posedge aclk);
    #1;
    in_tvalid = '0;
    @(negedge aclk);
    checks++;
    if (data_o_tvalid !== 1'b0 || data_o_tdata !== 10'd0) begin
      errors++;
      $display("FAIL defaults_latency: got valid=%0b data=%0d one edge after handshake, expected 0/0",
               data_o_tvalid, data_o_tdata);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (data_o_tvalid !== 1'b1 || data_o_tdata !== 10'd10) begin
      errors++;
      $display("FAIL defaults_sum: got valid=%0b data=%0d expected valid=1 data=10",
               data_o_tvalid, data_o_tdata);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (data_o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL defaults_consumed: got valid=%0b expected 0", data_o_tvalid);
    end
  endtask

  task automatic test_max();
    clear_log();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        src[k][i] = 8'd255;
      end
    end
    setup(16);
    out_tready = 1'b1;
    drive(30, 100, 100);
    checks++;
    if (out_cnt !== 16) begin
      errors++;
      $display("FAIL max_count: got %0d outputs expected 16", out_cnt);
    end
    for (int i = 0; i < 16 && i < out_cnt; i++) begin
      checks++;
      if (out_log[i] !== 10'd1020) begin
        errors++;
        $display("FAIL max_sum[%0d]: got %0d expected 1020", i, out_log[i]);
      end
    end
    if (out_cnt >= 16) begin
      checks++;
      if (out_cyc[15] - out_cyc[0] !== 15) begin
        errors++;
        $display("FAIL max_throughput: got span %0d cycles for 16 outputs expected 15",
                 out_cyc[15] - out_cyc[0]);
      end
    end
  endtask

  task automatic test_stall();
    int exp;
    clear_log();
    fill_random(4);
    src[3][0] = 8'd5;
    src[3][1] = 8'd6;
    src[3][2] = 8'd7;
    src[3][3] = 8'd8;
    setup(4);
    nbeats[3] = 0;
    out_tready = 1'b1;
    drive(10, 100, 100);
    checks++;
    if (data_i_tready !== 4'b1000) begin
      errors++;
      $display("FAIL stall_tready: got %b expected 1000", data_i_tready);
    end
    checks++;
    if (out_cnt !== 0) begin
      errors++;
      $display("FAIL stall_no_output: got %0d outputs expected 0", out_cnt);
    end
    nbeats[3] = 4;
    drive(15, 100, 100);
    checks++;
    if (out_cnt !== 4) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs expected 4", out_cnt);
    end
    for (int i = 0; i < 4 && i < out_cnt; i++) begin
      exp = 0;
      for (int k = 0; k < 4; k++) exp += int'(src[k][i]);
      checks++;
      if (out_log[i] !== 10'(exp)) begin
        errors++;
        $display("FAIL stall_sum[%0d]: got %0d expected %0d", i, out_log[i], exp);
      end
    end
    checks++;
    if (data_i_tready !== 4'hF) begin
      errors++;
      $display("FAIL stall_resume: got %b expected 1111", data_i_tready);
    end
  endtask

  task automatic test_backpressure();
    int exp;
    clear_log();
    fill_random(5);
    src[0][0] = 8'd10;
    src[1][0] = 8'd11;
    src[2][0] = 8'd10;
    src[3][0] = 8'd11;
    setup(5);
    out_tready = 1'b0;
    drive(12, 100, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      checks++;
      if (data_o_tvalid !== 1'b1 || data_o_tdata !== 10'd42) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d expected valid=1 data=42",
                 c, data_o_tvalid, data_o_tdata);
      end
    end
    checks++;
    if (data_i_tready !== 4'h0) begin
      errors++;
      $display("FAIL bp_full: got tready=%b expected 0000", data_i_tready);
    end
    drive(20, 100, 100);
    checks++;
    if (out_cnt !== 5) begin
      errors++;
      $display("FAIL bp_count: got %0d outputs expected 5", out_cnt);
    end
    for (int i = 0; i < 5 && i < out_cnt; i++) begin
      exp = 0;
      for (int k = 0; k < 4; k++) exp += int'(src[k][i]);
      checks++;
      if (out_log[i] !== 10'(exp)) begin
        errors++;
        $display("FAIL bp_sum[%0d]: got %0d expected %0d", i, out_log[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    fill_random(4);
    setup(4);
    out_tready = 1'b0;
    drive(10, 100, 0);
    @(posedge aclk);
    #3;
    in_tdata  = $urandom;
    in_tvalid = 4'hF;
    areset    = 1'b1;
    #1;
    checks++;
    if (data_o_tvalid !== 1'b0 || data_o_tdata !== 10'd0) begin
      errors++;
      $display("FAIL midreset_async: got valid=%0b data=%0d expected valid=0 data=0",
               data_o_tvalid, data_o_tdata);
    end
    in_tvalid = '0;
    setup(0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (data_i_tready !== 4'hF) begin
      errors++;
      $display("FAIL midreset_tready: got %b expected 1111", data_i_tready);
    end
    clear_log();
    for (int k = 0; k < 4; k++) src[k][0] = 8'd1;
    setup(1);
    drive(6, 100, 100);
    checks++;
    if (out_cnt !== 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d outputs expected 1", out_cnt);
    end else begin
      checks++;
      if (out_log[0] !== 10'd4) begin
        errors++;
        $display("FAIL midreset_sum: got %0d expected 4", out_log[0]);
      end
    end
  endtask

  task automatic test_random();
    int exp;
    clear_log();
    fill_random(40);
    setup(40);
    drive(600, 60, 70);
    drive(20, 100, 100);
    checks++;
    if (out_cnt !== 40) begin
      errors++;
      $display("FAIL random_count: got %0d outputs expected 40", out_cnt);
    end
    for (int i = 0; i < 40 && i < out_cnt; i++) begin
      exp = 0;
      for (int k = 0; k < 4; k++) exp += int'(src[k][i]);
      checks++;
      if (out_log[i] !== 10'(exp)) begin
        errors++;
        $display("FAIL random_sum[%0d]: got %0d expected %0d", i, out_log[i], exp);
      end
    end
  endtask

`ifdef ADDER_AXIS_CNT_EN
  task automatic test_counter();
    @(negedge aclk);
    areset = 1'b1;
    in_tvalid = '0;
    @(negedge aclk);
    areset = 1'b0;
    checks++;
    if (trans_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL cnt_reset: got %0d expected 0", trans_cnt_o);
    end
    clear_log();
    fill_random(100);
    setup(100);
    drive(1500, 50, 50);
    drive(30, 100, 100);
    @(negedge aclk);
    checks++;
    if (trans_cnt_o !== 32'd100) begin
      errors++;
      $display("FAIL cnt_total: got %0d expected 100", trans_cnt_o);
    end
  endtask
`endif

  initial begin
    setup(0);
    test_reset();
    test_defaults();
    test_max();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef ADDER_AXIS_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_axis_multi.md
Name: adder_axis_multi

Overview:
Parametrised N-channel AXI-Stream adder, successor of the two-input naive adder. Each input channel is buffered in its own FIFO so channels stall independently. One output beat is produced per complete set of operands (one beat from every channel), at full throughput of one sum per clock. The output is registered and sits directly on the downstream AXI-Stream sink.

Parameters:
WIDTH, 8, bit width of each operand.
N_CH, 4, number of input channels (>= 2).
FIFO_DEPTH, 4, entries per input FIFO (power of two, >= 2).
OUT_WIDTH, WIDTH+$clog2(N_CH), result width (localparam, not overridable).

Ports:
aclk  in  1  clock, all logic on rising edge.
areset  in  1  reset, asynchronous, active-high.
data_i_tdata  in  N_CH*WIDTH  packed operands; channel k occupies bits [k*WIDTH +: WIDTH].
data_i_tvalid  in  N_CH  per-channel valid.
data_i_tready  out  N_CH  per-channel ready.
data_o_tdata  out  OUT_WIDTH  sum of one beat from each channel.
data_o_tvalid  out  1  output valid.
data_o_tready  in  1  downstream ready.
trans_cnt_o  out  32  output transfer count (only with ADDER_AXIS_CNT_EN).

Behaviour:
- Reset (areset high, asynchronous):
  - All FIFO pointers and levels cleared.
  - data_o_tvalid=0, data_o_tdata=0, data_i_tready=all 1s immediately after release.
  - Reset mid-operation discards buffered operands and any pending output beat.
- Input side, per channel k:
  - data_i_tready[k] = !full[k]; registered-state derived, no combinational path from any tvalid or from data_o_tready.
  - Push on data_i_tvalid[k] && data_i_tready[k].
  - Channels are independent: a stalled channel never blocks pushes on the others until their own FIFOs fill.
- Join/fire:
  - fire = (all N_CH FIFOs non-empty) && (!data_o_tvalid || data_o_tready).
  - On fire:
    - pop the head of every FIFO;
    - data_o_tdata <= unsigned sum of all N_CH heads, each zero-extended to OUT_WIDTH (no overflow possible);
    - data_o_tvalid <= 1.
  - Else if data_o_tready: data_o_tvalid <= 0.
  - data_o_tdata holds its value while tvalid=1 and tready=0 (AXI stability). It is don't-care-stable (unchanged) when tvalid=0.
- Latency and throughput:
  - The last operand handshake at edge t causes data_o_tvalid=1 after edge t+1.
  - Sustained one sum per clock when all inputs are valid and tready=1.
- Boundary conditions:
  - Push and pop on the same FIFO in the same cycle: the level is unchanged and both operations take effect.
  - Full FIFO: tready=0. A pop that cycle frees the slot for the next cycle only; there is no same-cycle bypass.
  - Empty FIFO: no fire, and no data ever bypasses the FIFO.
  - Pointer wrap-around at FIFO_DEPTH uses an extra pointer bit to distinguish full from empty.
- Ordering: the i-th output equals the sum of the i-th accepted beat of each channel. Sums are never reordered or dropped.

Optional Feature:
Macro ADDER_AXIS_CNT_EN.
- Defined:
  - port trans_cnt_o[31:0] exists;
  - resets to 0;
  - increments on each data_o_tvalid && data_o_tready edge;
  - wraps 0xFFFFFFFF -> 0.
- Undefined: the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
1. Defaults: one beat per channel of 1,2,3,4 with tready=1 -> one output tdata=10 one cycle after the last handshake; outputs remain 0/0 before it.
2. Max values: all channels 255 for 16 beats, continuous valid, tready=1 -> 16 outputs of 1020 on consecutive cycles (throughput 1/clk after first).
3. Channel stall: channels 0-2 send 4 beats each while channel 3 is idle -> ch0-2 tready drop to 0 after 4 pushes; no output. Channel 3 then sends 5,6,7,8 -> four outputs, each correct per index; the previously stalled channels resume tready=1.
4. Backpressure: data_o_tready=0 for 10 cycles with a pending result 42 -> tdata stays 42 and tvalid stays 1. The FIFOs fill and all tready go to 0. On release, all sums drain in order with no loss.
5. Reset mid-stream: assert areset with 3 beats buffered and tvalid=1 -> tvalid=0 and tdata=0 immediately (asynchronous), all tready=1 after release, and the next set 1,1,1,1 yields 4.
6. With ADDER_AXIS_CNT_EN: after 100 random transfers under random delays, trans_cnt_o=100. A forced preload of 0xFFFFFFFF followed by one transfer gives 0.
